// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - execute-stage divide/modulo controller driving a multicycle divider
// Optional signed mode: define DIV_SIGNED_EN.
module div_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_mod,
    input  logic [3:0]  req_rd,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        req_ready,
    output logic        stall,
    output logic        wb_valid,
    output logic [3:0]  wb_rd,
    output logic [15:0] wb_data,
    input  logic        wb_ready,
    output logic        div0,
    output logic        timeout_err,
    output logic [15:0] div_dividend,
    output logic [15:0] div_divisor,
    output logic [1:0]  div_opctrl,
    input  logic [15:0] div_out,
    input  logic        div_busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t        state, next_state;
    logic          mod_r;
    logic [3:0]    rd_r;
    logic [15:0]   a_r, b_r;
    logic [15:0]   data_r;
    logic          div0_r;
    logic          terr_r;
    logic [CW-1:0] wait_cnt;
    logic [15:0]   op_a, op_b, result;
    logic          wait_expired;

`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r;
    // Divider sees magnitudes; signs are restored on the captured result.
    assign op_a   = a_r[15] ? (~a_r + 16'd1) : a_r;
    assign op_b   = b_r[15] ? (~b_r + 16'd1) : b_r;
    assign neg_q  = a_r[15] ^ b_r[15];
    assign neg_r  = a_r[15];
    assign result = mod_r ? (neg_r ? (~div_out + 16'd1) : div_out)
                          : (neg_q ? (~div_out + 16'd1) : div_out);
`else
    assign op_a   = a_r;
    assign op_b   = b_r;
    assign result = div_out;
`endif

    assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        next_state   = state;
        req_ready    = 1'b0;
        wb_valid     = 1'b0;
        stall        = 1'b0;
        div_opctrl   = 2'b00;
        div_dividend = 16'd0;
        div_divisor  = 16'd0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (req_valid)
                    next_state = (req_b == 16'd0) ? WB : ISSUE;
            end
            ISSUE: begin
                stall        = 1'b1;
                div_opctrl   = {1'b1, mod_r};
                div_dividend = op_a;
                div_divisor  = op_b;
                next_state   = WAIT;
            end
            WAIT: begin
                stall        = 1'b1;
                div_opctrl   = {1'b0, mod_r};
                div_dividend = op_a;
                div_divisor  = op_b;
                if (!div_busy || wait_expired)
                    next_state = WB;
            end
            WB: begin
                wb_valid = 1'b1;
                stall    = !wb_ready;
                if (wb_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mod_r    <= 1'b0;
            rd_r     <= 4'd0;
            a_r      <= 16'd0;
            b_r      <= 16'd0;
            data_r   <= 16'd0;
            div0_r   <= 1'b0;
            terr_r   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mod_r    <= req_mod;
                        rd_r     <= req_rd;
                        a_r      <= req_a;
                        b_r      <= req_b;
                        div0_r   <= (req_b == 16'd0);
                        wait_cnt <= '0;
                        // Divide-by-zero result is known now; the divider is bypassed.
                        if (req_b == 16'd0)
                            data_r <= req_mod ? req_a : 16'hFFFF;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (!div_busy) begin
                        data_r <= result;
                    end else if (wait_expired) begin
                        data_r <= 16'hFFFF;
                        terr_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb_rd       = rd_r;
    assign wb_data     = data_r;
    assign div0        = div0_r;
    assign timeout_err = terr_r;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed self-checking bench for div_ctrl with a stub divider
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_mod;
    logic [3:0]  req_rd;
    logic [15:0] req_a, req_b;
    logic        req_ready, stall, wb_valid, wb_ready, div0, timeout_err;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data, div_dividend, div_divisor, div_out;
    logic [1:0]  div_opctrl;
    logic        div_busy;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int cyc;
    int s0;
    logic hung = 1'b0;

    logic [15:0] d_a, d_b;
    logic        d_mod;
    int          busy_cnt;

    always #5 clk = ~clk;

    div_ctrl #(.TIMEOUT(40)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_mod(req_mod), .req_rd(req_rd),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .stall(stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
        .div0(div0), .timeout_err(timeout_err),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_opctrl(div_opctrl), .div_out(div_out), .div_busy(div_busy)
    );

    // Stub divider: three busy cycles after a start pulse, or stuck busy when hung.
    always @(posedge clk) begin
        if (reset) begin
            busy_cnt <= 0;
        end else if (div_opctrl[1]) begin
            busy_cnt <= 3;
            d_a      <= div_dividend;
            d_b      <= div_divisor;
            d_mod    <= div_opctrl[0];
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign div_busy = hung || (busy_cnt != 0);
    assign div_out  = (d_b == 16'd0) ? 16'd0 : (d_mod ? d_a % d_b : d_a / d_b);

    always @(negedge clk) if (div_opctrl[1]) starts <= starts + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic m,
                            input logic [3:0] rd);
        @(negedge clk);
        req_valid = 1'b1; req_a = a; req_b = b; req_mod = m; req_rd = rd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_wb(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_valid && n < 200);
        if (!wb_valid) check("wb_valid_bound", 32'(wb_valid), 32'd1);
    endtask

    task automatic finish_wb;
        wb_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_mod = 1'b0; req_rd = 4'd0;
        req_a = 16'd0; req_b = 16'd0; wb_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_outputs", {req_ready, stall, wb_valid, div0, timeout_err, div_opctrl},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
        check("rst_data", {wb_rd, wb_data, div_dividend[11:0]}, 32'd0);

        // 100 / 7 quotient
        s0 = starts;
        start_op(16'd100, 16'd7, 1'b0, 4'd3);
        wait_wb(cyc);
        check("q_data", 32'(wb_data), 32'd14);
        check("q_rd_div0", {wb_rd, div0}, {4'd3, 1'b0});
        check("q_latency", 32'(cyc), 32'd6);
        check("q_one_start", 32'(starts - s0), 32'd1);
        finish_wb();

        // 100 % 7 remainder
        s0 = starts;
        start_op(16'd100, 16'd7, 1'b1, 4'd4);
        wait_wb(cyc);
        check("r_data", 32'(wb_data), 32'd2);
        check("r_one_start", 32'(starts - s0), 32'd1);
        finish_wb();

        // Divide by zero bypass
        s0 = starts;
        start_op(16'h1234, 16'd0, 1'b0, 4'd7);
        wait_wb(cyc);
        check("z_q_data", 32'(wb_data), 32'hFFFF);
        check("z_q_div0_rd", {wb_rd, div0}, {4'd7, 1'b1});
        check("z_q_latency", 32'(cyc), 32'd1);
        finish_wb();
        start_op(16'h1234, 16'd0, 1'b1, 4'd7);
        wait_wb(cyc);
        check("z_r_data", 32'(wb_data), 32'h1234);
        check("z_no_start", 32'(starts - s0), 32'd0);
        finish_wb();

        // -7 and 2
        start_op(16'hFFF9, 16'd2, 1'b0, 4'd1);
        wait_wb(cyc);
`ifdef DIV_SIGNED_EN
        check("s_q_data", 32'(wb_data), 32'hFFFD);
`else
        check("s_q_data", 32'(wb_data), 32'h7FFC);
`endif
        finish_wb();
        start_op(16'hFFF9, 16'd2, 1'b1, 4'd1);
        wait_wb(cyc);
`ifdef DIV_SIGNED_EN
        check("s_r_data", 32'(wb_data), 32'hFFFF);
`else
        check("s_r_data", 32'(wb_data), 32'h0001);
`endif
        finish_wb();
`ifdef DIV_SIGNED_EN
        start_op(16'h8000, 16'hFFFF, 1'b0, 4'd2);
        wait_wb(cyc);
        check("s_min_q", 32'(wb_data), 32'h8000);
        finish_wb();
        start_op(16'h8000, 16'hFFFF, 1'b1, 4'd2);
        wait_wb(cyc);
        check("s_min_r", 32'(wb_data), 32'h0000);
        finish_wb();
`endif

        // Backpressure in WB with a stray request during WAIT
        wb_ready = 1'b0;
        s0 = starts;
        start_op(16'd100, 16'd7, 1'b0, 4'd5);
        req_valid = 1'b1; req_a = 16'd50; req_b = 16'd5; req_rd = 4'd9;
        @(negedge clk);
        @(negedge clk);
        check("bp_wait_ready", {req_ready, stall}, {1'b0, 1'b1});
        wait_wb(cyc);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold", {wb_valid, stall, wb_rd, wb_data}, {1'b1, 1'b1, 4'd5, 16'd14});
        end
        check("bp_one_start", 32'(starts - s0), 32'd1);
        finish_wb();
        check("bp_done", {wb_valid, req_ready}, {1'b0, 1'b1});

        // Reset during WAIT
        start_op(16'd100, 16'd7, 1'b0, 4'd6);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("mr_in_wait", 32'(stall), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mr_outputs", {req_ready, stall, wb_valid, div0, timeout_err, div_opctrl},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
        check("mr_data", {wb_rd, wb_data}, 20'd0);
        start_op(16'd100, 16'd7, 1'b0, 4'd6);
        wait_wb(cyc);
        check("mr_fresh", {wb_rd, wb_data}, {4'd6, 16'd14});
        finish_wb();

        // Hung divider
        hung = 1'b1;
        start_op(16'd100, 16'd7, 1'b0, 4'd8);
        wait_wb(cyc);
        check("to_latency", 32'(cyc), 32'd42);
        check("to_data", {timeout_err, wb_data}, {1'b1, 16'hFFFF});
        finish_wb();
        hung = 1'b0;
        start_op(16'd100, 16'd7, 1'b0, 4'd8);
        wait_wb(cyc);
        check("to_sticky", {timeout_err, wb_data}, {1'b1, 16'd14});
        finish_wb();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("to_cleared", 32'(timeout_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Execute-stage controller that initiates divide/modulo operations on the multicycle `div` unit and returns results to register writeback. It accepts one request at a time from the pipeline, stalls the pipeline while the divider works, and captures the result on the divider's completion edge. It also handles divide-by-zero without involving the divider and guards against a hung divider with a timeout.

## Interface
- `TIMEOUT`, default 40: maximum cycles spent in WAIT before abort.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: execute stage presents a div/mod instruction.
- `req_mod` in 1: 1 selects remainder, 0 selects quotient.
- `req_rd` in 4: destination register.
- `req_a`, `req_b` in 16: dividend, divisor.
- `req_ready` out 1: high only in IDLE.
- `stall` out 1: pipeline stall request.
- `wb_valid` out 1, `wb_rd` out 4, `wb_data` out 16, `wb_ready` in 1: writeback handshake.
- `div0` out 1: qualifies `wb_valid`; result came from the divide-by-zero bypass.
- `timeout_err` out 1: sticky; set on abort, cleared only by `reset`.
- `div_dividend`, `div_divisor` out 16: divider operands.
- `div_opctrl` out 2: bit1 = start, bit0 = select remainder.
- `div_out` in 16, `div_busy` in 1: divider result and busy.

## Operation
- States: IDLE, ISSUE, WAIT, WB.
- IDLE
  - Request accepted when `req_valid && req_ready`.
  - On accept, latch `req_mod`, `req_rd`, and both operands.
  - `req_b == 0`: go to WB with `div0=1`.
    - Quotient result: 16'hFFFF.
    - Remainder result: `req_a`.
  - Otherwise: go to ISSUE.
- ISSUE
  - `div_opctrl = {1, mod}`, operands driven from the latches.
  - Exactly one cycle, then go to WAIT.
- WAIT
  - `div_opctrl = {0, mod}`. Bit0 stays stable from ISSUE through the capture cycle.
  - Capture `div_out` on the first WAIT cycle with `div_busy == 0`, then go to WB.
  - A cycle counter counts WAIT cycles. Reaching `TIMEOUT` without capture: abort, go to WB with `wb_data = 16'hFFFF`, set `timeout_err`.
- WB
  - `wb_valid = 1`; `wb_rd`, `wb_data`, `div0` held stable.
  - `wb_ready = 1` completes writeback, then go to IDLE.
- `req_valid` is ignored outside IDLE.
- `div_opctrl` = 0 and operands = 0 in IDLE and WB.
- `stall` is high when any of the following holds:
  - IDLE and `req_valid`;
  - state is ISSUE or WAIT;
  - WB and `!wb_ready`.
- Reset values: state IDLE, `req_ready=1`, `stall=0`, `wb_valid=0`, `wb_rd=0`, `wb_data=0`, `div0=0`, `timeout_err=0`, `div_opctrl=0`, `div_*` operands 0.
- Reset mid-operation (any state): return to IDLE next edge and drop the pending result. The divider shares `reset`, so no cleanup is needed.

## Timing
- Cycle 0: accept in IDLE.
- Cycle 1: ISSUE, or WB for divide-by-zero. For divide-by-zero, `wb_valid` is high in cycle 1.
- Cycle 2 onward: WAIT.
  - Capture occurs in the first WAIT cycle k with `div_busy=0`.
  - `wb_valid` rises at cycle k+1.
- Latency to `wb_valid` is therefore k+1, independent of the divider's internal cycle count.
- Back-to-back requests: after WB completes at cycle n, IDLE at n+1 accepts the next request. Minimum issue interval is 4 cycles for divider operations and 2 for divide-by-zero.

## Configuration
- `DIV_SIGNED_EN` defined: operands are two's complement.
  - Magnitudes are sent to the divider.
  - Quotient is negated when operand signs differ.
  - Remainder takes the dividend's sign.
  - -32768/-1 yields 16'h8000 quotient and 0 remainder.
  - Sign fix-up is registered at capture, so latency is unchanged.
  - Divide-by-zero results are unchanged: 16'hFFFF and dividend.
- `DIV_SIGNED_EN` undefined: operands and results are unsigned; no sign logic is instantiated.

## Test plan
- Unsigned division, `wb_ready=1`:
  - a=100, b=7, mod=0, rd=3 → `wb_data=14`, `wb_rd=3`, `div0=0`.
  - Same operands with mod=1 → `wb_data=2`.
  - Exactly one cycle with `div_opctrl[1]=1` per request.
- Divide by zero: a=0x1234, b=0.
  - mod=0 → `wb_data=0xFFFF`, `div0=1`, `wb_valid` at cycle 1, `div_opctrl[1]` never asserted.
  - mod=1 → `wb_data=0x1234`.
- Signed arithmetic:
  - With `DIV_SIGNED_EN`: a=0xFFF9 (-7), b=2 → quotient 0xFFFD, remainder 0xFFFF.
  - Without `DIV_SIGNED_EN`, same operands → quotient 0x7FFC, remainder 1.
- Writeback backpressure and re-request:
  - Hold `wb_ready=0` for 3 cycles in WB → `wb_valid`, `wb_data`, `stall` held stable.
  - `req_valid` asserted during WAIT → ignored.
- Reset mid-operation: assert `reset` during WAIT.
  - Next cycle: all outputs at reset values.
  - A fresh 100/7 request then completes with 14.
- Hung divider: stub `div_busy` stuck at 1.
  - WB after `TIMEOUT` WAIT cycles with `wb_data=0xFFFF` and `timeout_err=1`.
  - `timeout_err` persists across a subsequent normal operation until `reset`.
